fft_twiddle_sequencer: RTL and testbench
========================================

// Module: fft_twiddle_sequencer
// PURPOSE
//  Upstream feeder of the complex multiplier in the radix-2 DIT FFT datapath. Walks all
//  stages/butterflies of an N-point FFT and emits, per butterfly, the two sample-memory
//  addresses plus the IEEE-754 single-precision twiddle W = cos(2*pi*t/N) - j*sin(2*pi*t/N).
//  The twiddle feeds the complex multiplier's b_real/b_im operands; the addresses drive the
//  sample RAM read port. Flow-controlled with valid/ready so downstream stalls are absorbed.
// PARAMETERS
//  LOG2N   3   log2 of FFT length N; legal 2..10
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      1-cycle request to sequence a full FFT
//  busy       out  1      high from accepted start until done
//  out_valid  out  1      butterfly descriptor valid
//  out_ready  in   1      consumer accepts descriptor when out_valid && out_ready
//  addr_top   out  LOG2N  address of upper butterfly input
//  addr_bot   out  LOG2N  address of lower butterfly input (addr_top + h)
//  tw_real    out  32     twiddle real part, IEEE-754 single
//  tw_im      out  32     twiddle imaginary part, IEEE-754 single (= -sin)
//  stage      out  4      stage index s of current descriptor
//  stage_last out  1      descriptor is the last butterfly of its stage
//  done       out  1      1-cycle pulse after final descriptor is accepted
// BEHAVIOUR
//  - Reset: state IDLE; busy, out_valid, stage_last, done = 0; addr_*, tw_*, stage = 0.
//    rst mid-run aborts immediately; no further descriptors, no done pulse.
//  - FSM IDLE -> RUN -> DRAIN -> IDLE.
//    IDLE: start=1 -> RUN, busy=1, counters s=0,k=0. start while busy is ignored.
//    RUN: descriptor register loads when (!out_valid || out_ready); after loading
//      (s=LOG2N-1, k=N/2-1) -> DRAIN. DRAIN: on acceptance of final descriptor -> IDLE,
//      busy=0 and done=1 same edge (done high exactly one cycle).
//  - Latency: start sampled at edge t -> out_valid=1 after edge t+1; then one descriptor
//    per cycle while out_ready=1; zero bubbles between stages.
//  - Stall: out_valid && !out_ready holds all outputs stable; counters frozen.
//  - Index math per stage s (h = 2^s), butterfly k in 0..N/2-1:
//    top = ((k>>s)<<(s+1)) | (k & (h-1)); bot = top + h; t = (k & (h-1)) << (LOG2N-1-s).
//  - k wraps N/2-1 -> 0 with s incrementing; stage_last=1 when k=N/2-1.
//  - Twiddle exact constants: t=0 -> 3F800000/00000000 (+0, never -0);
//    t=N/4 -> 00000000/BF800000. Others: round-to-nearest of cos / -sin.
//  - Outputs all registered; no combinational path from out_ready to any output except
//    through the register enable.
// STRUCTURE
//  - Shared package fft_pkg: FP_ONE, FP_ZERO, FP_NEG_ONE constants; LOG2N_MAX=10;
//    FSM state encoding (IDLE/RUN/DRAIN).
//  - One sub-module fft_twiddle_rom: combinational case ROM, input t[LOG2N-2:0], outputs
//    {tw_real, tw_im}; table generated for N/2 entries, N up to 1024.
//  - Top holds FSM, s/k counters, address math and output register.
// TESTING (LOG2N=3, N=8)
//  - Reset: rst=1 two cycles -> every output 0; start held high during rst is not taken.
//  - Full run, out_ready=1: start pulse -> 12 descriptors back-to-back: s0 (0,1)(2,3)(4,5)(6,7)
//    t=0; s1 (0,2)(1,3)(4,6)(5,7) t=0,2,0,2; s2 (0,4)(1,5)(2,6)(3,7) t=0..3; done once.
//  - Twiddles: t=1 -> 3F3504F3/BF3504F3; t=2 -> 00000000/BF800000; t=0 -> 3F800000/00000000.
//  - Stall: drop out_ready for 3 cycles at s1,k=2 -> (4,6) held stable, none lost or duplicated.
//  - start while busy (mid s1) -> ignored, sequence and done count unchanged.
//  - rst at s2,k=1 -> next cycle out_valid=0, busy=0, no done; new start -> fresh run from s0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the radix-2 DIT FFT twiddle sequencer.
package fft_pkg;

  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
  localparam int          LOG2N_MAX  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle ROM: W^t = cos(2*pi*t/N) - j*sin(2*pi*t/N) as IEEE-754 single pairs,
// tabulated at elaboration for t = 0..N/2-1 using Q60 fixed-point series.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int LOG2N = 3
) (
  input  logic [LOG2N-2:0] t,
  output logic [31:0]      tw_real,
  output logic [31:0]      tw_im
);

  localparam int HALF_N  = 1 << (LOG2N - 1);
  localparam int QUART_N = 1 << (LOG2N - 2);
  localparam int FRAC    = 60;

  typedef logic signed [127:0] q_t;

  localparam q_t ONE_Q = q_t'(128'sd1) <<< FRAC;
  localparam q_t PI_Q  = q_t'(64'h3243_F6A8_885A_308D);

  function automatic q_t qmul(input q_t a, input q_t b);
    q_t p;
    p = a * b;
    return p >>> FRAC;
  endfunction

  // Maclaurin series; arguments never exceed pi/2, so 14 terms are far below float32 precision.
  function automatic q_t taylor(input q_t x, input logic odd);
    q_t x2, term, sum;
    x2   = qmul(x, x);
    term = odd ? x : ONE_Q;
    sum  = term;
    for (int n = 1; n < 14; n++) begin
      if (odd) term = -(qmul(term, x2) / q_t'((2 * n) * (2 * n + 1)));
      else     term = -(qmul(term, x2) / q_t'((2 * n - 1) * (2 * n)));
      sum = sum + term;
    end
    return sum;
  endfunction

  function automatic logic [31:0] to_fp32(input q_t v);
    logic sgn;
    q_t   m, mant, rem, half;
    int   p, sh, e;
    sgn = (v < q_t'(128'sd0));
    m   = sgn ? -v : v;
    if (m == q_t'(128'sd0)) return 32'h0000_0000;
    p = 0;
    for (int i = 0; i < 127; i++) begin
      if (m[i]) p = i;
    end
    sh   = p - 23;
    mant = m >>> sh;
    rem  = m - (mant <<< sh);
    half = q_t'(128'sd1) <<< (sh - 1);
    if ((rem > half) || ((rem == half) && mant[0])) mant = mant + q_t'(128'sd1);
    e = p - FRAC + 127;
    if (mant[24]) begin
      mant = mant >>> 1;
      e    = e + 1;
    end
    return {sgn, e[7:0], mant[22:0]};
  endfunction

  // Second-quadrant entries reuse the first-quadrant series via a pi/2 rotation.
  function automatic logic [HALF_N*64-1:0] build_table();
    logic [HALF_N*64-1:0] tbl;
    q_t th, c, s;
    int u;
    tbl = '0;
    for (int i = 0; i < HALF_N; i++) begin
      if (i == 0) begin
        tbl[i*64 +: 64] = {FP_ONE, FP_ZERO};
      end else if (i == QUART_N) begin
        tbl[i*64 +: 64] = {FP_ZERO, FP_NEG_ONE};
      end else begin
        u  = (i < QUART_N) ? i : i - QUART_N;
        th = (PI_Q * q_t'(u)) >>> (LOG2N - 1);
        c  = taylor(th, 1'b0);
        s  = taylor(th, 1'b1);
        if (i < QUART_N) tbl[i*64 +: 64] = {to_fp32(c), to_fp32(-s)};
        else             tbl[i*64 +: 64] = {to_fp32(-s), to_fp32(-c)};
      end
    end
    return tbl;
  endfunction

  localparam logic [HALF_N*64-1:0] TABLE = build_table();

  // Combinational lookup of the selected entry.
  always_comb begin
    {tw_real, tw_im} = TABLE[int'(t) * 64 +: 64];
  end

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// Walks every stage/butterfly of a radix-2 DIT FFT and emits registered address pairs
// plus float32 twiddles under valid/ready flow control.
module fft_twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] addr_top,
  output logic [LOG2N-1:0] addr_bot,
  output logic [31:0]      tw_real,
  output logic [31:0]      tw_im,
  output logic [3:0]       stage,
  output logic             stage_last,
  output logic             done
);

  localparam int            KW     = LOG2N - 1;
  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [3:0]    S_LAST = 4'(LOG2N - 1);

  state_e           state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic             busy_q, busy_d, valid_q, valid_d, done_q, done_d, last_q, last_d;
  logic [LOG2N-1:0] top_q, top_d, bot_q, bot_d;
  logic [31:0]      re_q, re_d, im_q, im_d;
  logic [3:0]       stage_q, stage_d;

  logic [LOG2N-1:0] k_ext, h, low, top, bot;
  logic [KW-1:0]    tw_idx;
  logic [31:0]      rom_re, rom_im;

  // Butterfly index math for the current (s, k).
  always_comb begin
    k_ext  = LOG2N'(k_q);
    h      = LOG2N'(1) << s_q;
    low    = k_ext & (h - LOG2N'(1));
    top    = ((k_ext >> s_q) << (s_q + 4'd1)) | low;
    bot    = top + h;
    tw_idx = KW'(low << (S_LAST - s_q));
  end

  fft_twiddle_rom #(.LOG2N(LOG2N)) u_rom (
    .t       (tw_idx),
    .tw_real (rom_re),
    .tw_im   (rom_im)
  );

  // Next-state logic: counters advance only when the descriptor register loads.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    last_d  = last_q;
    top_d   = top_q;
    bot_d   = bot_q;
    re_d    = re_q;
    im_d    = im_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          s_d     = 4'd0;
          k_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!valid_q || out_ready) begin
          valid_d = 1'b1;
          top_d   = top;
          bot_d   = bot;
          re_d    = rom_re;
          im_d    = rom_im;
          stage_d = s_q;
          last_d  = (k_q == K_LAST);
          if (k_q == K_LAST) begin
            k_d = '0;
            if (s_q == S_LAST) state_d = ST_DRAIN;
            else               s_d     = s_q + 4'd1;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= 4'd0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      top_q   <= '0;
      bot_q   <= '0;
      re_q    <= 32'h0000_0000;
      im_q    <= 32'h0000_0000;
      stage_q <= 4'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      last_q  <= last_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      re_q    <= re_d;
      im_q    <= im_d;
      stage_q <= stage_d;
    end
  end

  assign busy       = busy_q;
  assign out_valid  = valid_q;
  assign done       = done_q;
  assign stage_last = last_q;
  assign addr_top   = top_q;
  assign addr_bot   = bot_q;
  assign tw_real    = re_q;
  assign tw_im      = im_q;
  assign stage      = stage_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer at N=8 with hand-computed descriptor tables.
module tb_fft_twiddle_sequencer;

  localparam int LOG2N = 3;
  localparam int NDESC = 12;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        busy, out_valid, stage_last, done;
  logic [2:0]  addr_top, addr_bot;
  logic [31:0] tw_real, tw_im;
  logic [3:0]  stage;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_top [NDESC] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_bot [NDESC] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_t   [NDESC] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  logic [31:0] exp_re [4] = '{32'h3F80_0000, 32'h3F35_04F3, 32'h0000_0000, 32'hBF35_04F3};
  logic [31:0] exp_im [4] = '{32'h0000_0000, 32'hBF35_04F3, 32'hBF80_0000, 32'hBF35_04F3};

  fft_twiddle_sequencer #(.LOG2N(LOG2N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .addr_top   (addr_top),
    .addr_bot   (addr_bot),
    .tw_real    (tw_real),
    .tw_im      (tw_im),
    .stage      (stage),
    .stage_last (stage_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_desc(input int idx, input string tag);
    check_eq($sformatf("%s_d%0d_top", tag, idx), 64'(addr_top), 64'(exp_top[idx]));
    check_eq($sformatf("%s_d%0d_bot", tag, idx), 64'(addr_bot), 64'(exp_bot[idx]));
    check_eq($sformatf("%s_d%0d_re", tag, idx), 64'(tw_real), 64'(exp_re[exp_t[idx]]));
    check_eq($sformatf("%s_d%0d_im", tag, idx), 64'(tw_im), 64'(exp_im[exp_t[idx]]));
    check_eq($sformatf("%s_d%0d_stage", tag, idx), 64'(stage), 64'(idx / 4));
    check_eq($sformatf("%s_d%0d_last", tag, idx), 64'(stage_last), 64'((idx % 4) == 3));
  endtask

  // One full FFT sequence; optional 3-cycle stall, start-while-busy pulse or mid-run reset.
  task automatic run_fft(input string tag, input int stall_idx, input int start_idx,
                         input int abort_idx);
    int idx, dones, done_cyc, first_acc, last_acc, stall_left;
    bit stalled, fired, bad;
    idx = 0; dones = 0; done_cyc = -1; first_acc = -1; last_acc = -1;
    stall_left = 0; stalled = 1'b0; fired = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_busy_on_start"}, 64'(busy), 64'd1);
    check_eq({tag, "_no_valid_yet"}, 64'(out_valid), 64'd0);
    for (int cyc = 0; cyc < 80; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 0) check_eq({tag, "_first_valid"}, 64'(out_valid), 64'd1);
      if (done) begin
        dones++;
        done_cyc = cyc;
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      end
      if (idx == abort_idx && out_valid) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq({tag, "_abort_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_abort_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_abort_done"}, 64'(done), 64'd0);
        check_eq({tag, "_abort_addr"}, 64'({addr_top, addr_bot, stage}), 64'd0);
        bad = 1'b0;
        for (int j = 0; j < 6; j++) begin
          tick();
          if (done || out_valid || busy) bad = 1'b1;
        end
        check_eq({tag, "_abort_quiet"}, 64'(bad), 64'd0);
        return;
      end
      if (idx == start_idx && !fired) begin
        start = 1'b1;
        fired = 1'b1;
      end
      if (idx == stall_idx && out_valid && !stalled) begin
        stalled    = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        check_desc(idx, {tag, "_held"});
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && idx < NDESC) begin
        check_desc(idx, tag);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        idx++;
      end
      if (dones > 0 && cyc >= done_cyc + 2) break;
    end
    out_ready = 1'b1;
    check_eq({tag, "_desc_count"}, 64'(idx), 64'(NDESC));
    check_eq({tag, "_done_count"}, 64'(dones), 64'd1);
    check_eq({tag, "_done_timing"}, 64'(done_cyc), 64'(last_acc + 1));
    check_eq({tag, "_no_bubbles"}, 64'(last_acc - first_acc),
             64'((stall_idx >= 0) ? 14 : 11));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_last", 64'(stage_last), 64'd0);
    check_eq("rst_addr", 64'({addr_top, addr_bot, stage}), 64'd0);
    check_eq("rst_tw", {tw_real, tw_im}, 64'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check_eq("start_in_rst_ignored", 64'(busy), 64'd0);

    run_fft("full", -1, -1, -1);
    run_fft("stall", 6, -1, -1);
    run_fft("busy_start", -1, 5, -1);
    run_fft("abort", -1, -1, 9);
    run_fft("rerun", -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
